// File: rtl/alu_arb.sv
// -----------------------------------------------------------------------------
// alu_arb
// Arbitrates two requesters onto one shared, externally instantiated ALU.
// Each operation is accepted in IDLE, is driven to the ALU from a captured
// operand register for one EXEC cycle, and its result is then held in RESP
// until the consumer takes it. Ties between the requesters are broken
// round-robin, and req0 wins the first tie after reset.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   reqN_valid/reqN_ready   per-requester handshake (N = 0, 1)
//   reqN_A, reqN_B          source operands            (ARCH_WIDTH)
//   reqN_Op                 ALU operation code         (ALUOp_WIDTH)
//   reqN_rotn/_MB/_ME       rotate amount, mask bounds (ROTL_WIDTH)
//   reqN_XER                XER snapshot for carry-in  (XER_WIDTH)
//   alu_A.._XER             registered operands to the shared ALU
//   alu_C, alu_D            ALU result and flags {CA,OV,CR0[3],CRX[3]}
//   rsp_valid/rsp_ready     response handshake
//   rsp_id, rsp_C, rsp_D    owner, result and flags of the held response
//   op_cnt                  completed responses, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module alu_arb #(
   parameter int ARCH_WIDTH  = 32,
   parameter int ALUOp_WIDTH = 4,
   parameter int ROTL_WIDTH  = 5,
   parameter int XER_WIDTH   = 32,
   parameter int ALU_D_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req0_valid,
   output logic                   req0_ready,
   input  logic [ARCH_WIDTH-1:0]  req0_A,
   input  logic [ARCH_WIDTH-1:0]  req0_B,
   input  logic [ALUOp_WIDTH-1:0] req0_Op,
   input  logic [ROTL_WIDTH-1:0]  req0_rotn,
   input  logic [ROTL_WIDTH-1:0]  req0_MB,
   input  logic [ROTL_WIDTH-1:0]  req0_ME,
   input  logic [XER_WIDTH-1:0]   req0_XER,
   input  logic                   req1_valid,
   output logic                   req1_ready,
   input  logic [ARCH_WIDTH-1:0]  req1_A,
   input  logic [ARCH_WIDTH-1:0]  req1_B,
   input  logic [ALUOp_WIDTH-1:0] req1_Op,
   input  logic [ROTL_WIDTH-1:0]  req1_rotn,
   input  logic [ROTL_WIDTH-1:0]  req1_MB,
   input  logic [ROTL_WIDTH-1:0]  req1_ME,
   input  logic [XER_WIDTH-1:0]   req1_XER,
   output logic [ARCH_WIDTH-1:0]  alu_A,
   output logic [ARCH_WIDTH-1:0]  alu_B,
   output logic [ALUOp_WIDTH-1:0] alu_Op,
   output logic [ROTL_WIDTH-1:0]  alu_rotn,
   output logic [ROTL_WIDTH-1:0]  alu_MB,
   output logic [ROTL_WIDTH-1:0]  alu_ME,
   output logic [XER_WIDTH-1:0]   alu_XER,
   input  logic [ARCH_WIDTH-1:0]  alu_C,
   input  logic [ALU_D_WIDTH-1:0] alu_D,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic                   rsp_id,
   output logic [ARCH_WIDTH-1:0]  rsp_C,
   output logic [ALU_D_WIDTH-1:0] rsp_D,
   output logic [15:0]            op_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic [ARCH_WIDTH-1:0]  a;
      logic [ARCH_WIDTH-1:0]  b;
      logic [ALUOp_WIDTH-1:0] op;
      logic [ROTL_WIDTH-1:0]  rotn;
      logic [ROTL_WIDTH-1:0]  mb;
      logic [ROTL_WIDTH-1:0]  me;
      logic [XER_WIDTH-1:0]   xer;
   } op_t;

   state_t state;
   op_t    op_q;        // the only source of the alu_* outputs
   op_t    op_sel;
   logic   op_id;
   logic   last_grant;  // 1 after reset so that req0 wins the first tie
   logic   grant0;
   logic   grant1;

   // A requester is granted if it is alone, or if it did not win last time.
   always_comb begin
      grant0 = req0_valid && (!req1_valid || last_grant);
      grant1 = req1_valid && (!req0_valid || !last_grant);
      // NOTE: op_sel is assigned before the if, so every path gives it a value and no latch is inferred.
      op_sel = '{a: req0_A, b: req0_B, op: req0_Op, rotn: req0_rotn,
                 mb: req0_MB, me: req0_ME, xer: req0_XER};
      if (grant1) begin
         op_sel = '{a: req1_A, b: req1_B, op: req1_Op, rotn: req1_rotn,
                    mb: req1_MB, me: req1_ME, xer: req1_XER};
      end
   end

   // state already reads IDLE while reset is applied, so ready is also gated
   // with rst_n to keep it low for the whole reset.
   assign req0_ready = rst_n && (state == IDLE) && grant0;
   assign req1_ready = rst_n && (state == IDLE) && grant1;

   assign alu_A    = op_q.a;
   assign alu_B    = op_q.b;
   assign alu_Op   = op_q.op;
   assign alu_rotn = op_q.rotn;
   assign alu_MB   = op_q.mb;
   assign alu_ME   = op_q.me;
   assign alu_XER  = op_q.xer;

   // NOTE: all state here updates with <=, so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         op_q       <= '0;
         op_id      <= 1'b0;
         last_grant <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_C      <= '0;
         rsp_D      <= '0;
         op_cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant0 || grant1) begin
                  op_q       <= op_sel;
                  op_id      <= grant1;
                  last_grant <= grant1;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               rsp_C     <= alu_C;
               rsp_D     <= alu_D;
               rsp_id    <= op_id;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               // Returning to IDLE here means the next acceptance comes one
               // cycle after the response handshake at the earliest.
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
                  if (op_cnt != 16'hFFFF) begin
                     op_cnt <= op_cnt + 16'd1;
                  end
               end
            end
            default: begin
               rsp_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arb.sv
// -----------------------------------------------------------------------------
// tb_alu_arb
// Directed bench for alu_arb. A small behavioural ALU stands in for the shared
// ALU. It is combinational from the alu_* outputs, with
// D = {CA, OV, CR0 = {LT,GT,EQ}, CRX = XER[31:29]}. A table of single-requester
// operations with hand-computed results runs first. Hand-written sequences then
// cover backpressure, operand isolation, reset during EXEC, round-robin ties
// and counter saturation.
// -----------------------------------------------------------------------------
module tb_alu_arb;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_ROTL = 4'd5;
   localparam logic [3:0] OP_ADDE = 4'd6;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic [4:0]  rotn;
      logic [4:0]  mb;
      logic [4:0]  me;
      logic [31:0] xer;
   } op_t;

   typedef struct {
      int          id;
      op_t         o;
      logic [31:0] exp_c;
      logic [7:0]  exp_d;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_A, req0_B, req1_A, req1_B;
   logic [3:0]  req0_Op, req1_Op;
   logic [4:0]  req0_rotn, req0_MB, req0_ME, req1_rotn, req1_MB, req1_ME;
   logic [31:0] req0_XER, req1_XER;
   logic [31:0] alu_A, alu_B, alu_XER, alu_C;
   logic [3:0]  alu_Op;
   logic [4:0]  alu_rotn, alu_MB, alu_ME;
   logic [7:0]  alu_D;
   logic        rsp_valid, rsp_ready, rsp_id;
   logic [31:0] rsp_C;
   logic [7:0]  rsp_D;
   logic [15:0] op_cnt;

   int n_checks = 0;
   int n_errors = 0;

   alu_arb dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_A(req0_A), .req0_B(req0_B), .req0_Op(req0_Op),
      .req0_rotn(req0_rotn), .req0_MB(req0_MB), .req0_ME(req0_ME), .req0_XER(req0_XER),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_A(req1_A), .req1_B(req1_B), .req1_Op(req1_Op),
      .req1_rotn(req1_rotn), .req1_MB(req1_MB), .req1_ME(req1_ME), .req1_XER(req1_XER),
      .alu_A(alu_A), .alu_B(alu_B), .alu_Op(alu_Op), .alu_rotn(alu_rotn),
      .alu_MB(alu_MB), .alu_ME(alu_ME), .alu_XER(alu_XER),
      .alu_C(alu_C), .alu_D(alu_D),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_C(rsp_C), .rsp_D(rsp_D), .op_cnt(op_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural shared ALU.
   logic [31:0] addend, res, rot;
   logic [32:0] sum;
   logic        cin, arith;
   logic [2:0]  cr0;
   always_comb begin
      addend = alu_B;
      cin    = 1'b0;
      arith  = 1'b1;
      case (alu_Op)
         OP_ADD:  ;
         OP_SUB:  begin addend = ~alu_B; cin = 1'b1; end
         OP_ADDE: cin = alu_XER[29];
         default: arith = 1'b0;
      endcase
      sum = {1'b0, alu_A} + {1'b0, addend} + {32'd0, cin};
      rot = (alu_A << alu_rotn) | (alu_A >> (6'd32 - {1'b0, alu_rotn}));
      case (alu_Op)
         OP_AND:  res = alu_A & alu_B;
         OP_OR:   res = alu_A | alu_B;
         OP_XOR:  res = alu_A ^ alu_B;
         OP_ROTL: res = rot;
         default: res = sum[31:0];
      endcase
      cr0   = res[31] ? 3'b100 : ((res == 32'd0) ? 3'b001 : 3'b010);
      alu_C = res;
      alu_D = {arith & sum[32],
               arith & (alu_A[31] == addend[31]) & (sum[31] != alu_A[31]),
               cr0, alu_XER[31:29]};
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input int id, input logic v, input op_t o);
      if (id == 0) begin
         req0_valid = v; req0_A = o.a; req0_B = o.b; req0_Op = o.op;
         req0_rotn = o.rotn; req0_MB = o.mb; req0_ME = o.me; req0_XER = o.xer;
      end else begin
         req1_valid = v; req1_A = o.a; req1_B = o.b; req1_Op = o.op;
         req1_rotn = o.rotn; req1_MB = o.mb; req1_ME = o.me; req1_XER = o.xer;
      end
   endtask

   function automatic op_t mk_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rotn, input logic [4:0] mb, input logic [4:0] me,
                                 input logic [31:0] xer);
      op_t o;
      o.a = a; o.b = b; o.op = op; o.rotn = rotn; o.mb = mb; o.me = me; o.xer = xer;
      return o;
   endfunction

   // One operation with rsp_ready high: accept, EXEC, RESP, back to IDLE.
   task automatic run_vec(input vec_t v, input string tag, input int exp_cnt);
      @(negedge clk);
      drive(v.id, 1'b1, v.o);
      #1;
      check({tag, "_ready_grant"}, (v.id == 0) ? req0_ready : req1_ready, 32'd1);
      check({tag, "_ready_other"}, (v.id == 0) ? req1_ready : req0_ready, 32'd0);
      @(negedge clk);
      drive(v.id, 1'b0, v.o);
      #1;
      check({tag, "_exec_rsp_valid"}, rsp_valid, 32'd0);
      check({tag, "_alu_A"},    alu_A,    v.o.a);
      check({tag, "_alu_B"},    alu_B,    v.o.b);
      check({tag, "_alu_Op"},   alu_Op,   v.o.op);
      check({tag, "_alu_rotn"}, alu_rotn, v.o.rotn);
      check({tag, "_alu_MB"},   alu_MB,   v.o.mb);
      check({tag, "_alu_ME"},   alu_ME,   v.o.me);
      check({tag, "_alu_XER"},  alu_XER,  v.o.xer);
      @(negedge clk);
      #1;
      check({tag, "_rsp_valid"}, rsp_valid, 32'd1);
      check({tag, "_rsp_C"},     rsp_C,     v.exp_c);
      check({tag, "_rsp_D"},     rsp_D,     v.exp_d);
      check({tag, "_rsp_id"},    rsp_id,    v.id);
      @(negedge clk);
      #1;
      check({tag, "_op_cnt"},     op_cnt,    exp_cnt);
      check({tag, "_idle_valid"}, rsp_valid, 32'd0);
   endtask

   vec_t vecs[8];
   op_t  op_x, op_y, op_t0, op_t1;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Hand-computed vectors: {id, op, expected C, expected D}.
      vecs[0] = '{0, mk_op(OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  5'd0,  5'd31, 32'h0000_0000), 32'h8000_0000, 8'h60};
      vecs[1] = '{1, mk_op(OP_SUB,  32'h0000_0005, 32'h0000_0008, 5'd1,  5'd2,  5'd3,  32'h2000_0000), 32'hFFFF_FFFD, 8'h21};
      vecs[2] = '{0, mk_op(OP_AND,  32'hF0F0_1234, 32'h0FF0_FFFF, 5'd7,  5'd8,  5'd9,  32'hE000_0000), 32'h00F0_1234, 8'h17};
      vecs[3] = '{1, mk_op(OP_XOR,  32'hAAAA_AAAA, 32'hAAAA_AAAA, 5'd31, 5'd30, 5'd29, 32'h0000_0000), 32'h0000_0000, 8'h08};
      vecs[4] = '{0, mk_op(OP_ADDE, 32'hFFFF_FFFF, 32'h0000_0000, 5'd10, 5'd11, 5'd12, 32'h2000_0000), 32'h0000_0000, 8'h89};
      vecs[5] = '{1, mk_op(OP_ADD,  32'h8000_0000, 32'h8000_0000, 5'd16, 5'd17, 5'd18, 32'h0000_0000), 32'h0000_0000, 8'hC8};
      vecs[6] = '{0, mk_op(OP_ROTL, 32'h8000_0001, 32'h0000_0000, 5'd4,  5'd3,  5'd28, 32'h0000_0000), 32'h0000_0018, 8'h10};
      vecs[7] = '{1, mk_op(OP_OR,   32'h1234_0000, 32'h0000_5678, 5'd21, 5'd22, 5'd23, 32'h4000_0000), 32'h1234_5678, 8'h12};

      op_x  = mk_op(OP_ADD, 32'h0000_0003, 32'h0000_0004, 5'd1, 5'd2, 5'd3, 32'h0000_0000);
      op_y  = mk_op(OP_XOR, 32'hDEAD_BEEF, 32'h1234_5678, 5'd31, 5'd7, 5'd9, 32'hFFFF_FFFF);
      op_t0 = mk_op(OP_ADD, 32'h0000_0001, 32'h0000_0001, 5'd0, 5'd0, 5'd0, 32'h0000_0000);
      op_t1 = mk_op(OP_ADD, 32'h0000_0002, 32'h0000_0002, 5'd0, 5'd0, 5'd0, 32'h0000_0000);

      // Reset state, with a request pending to show that ready is held low.
      rst_n     = 1'b0;
      rsp_ready = 1'b1;
      drive(0, 1'b1, op_x);
      drive(1, 1'b1, op_y);
      #2;
      check("rst_req0_ready", req0_ready, 32'd0);
      check("rst_req1_ready", req1_ready, 32'd0);
      check("rst_rsp_valid",  rsp_valid,  32'd0);
      check("rst_rsp_C",      rsp_C,      32'd0);
      check("rst_rsp_D",      rsp_D,      32'd0);
      check("rst_rsp_id",     rsp_id,     32'd0);
      check("rst_op_cnt",     op_cnt,     32'd0);
      check("rst_alu_A",      alu_A,      32'd0);
      check("rst_alu_XER",    alu_XER,    32'd0);
      drive(0, 1'b0, op_x);
      drive(1, 1'b0, op_y);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Table: one requester at a time, rsp_ready high.
      for (int i = 0; i < 8; i++) begin
         run_vec(vecs[i], $sformatf("v%0d", i), i + 1);
      end

      // Backpressure: result held for 5 cycles while req1 waits.
      rsp_ready = 1'b0;
      @(negedge clk);
      drive(0, 1'b1, op_x);
      #1;
      check("bp_req0_ready", req0_ready, 32'd1);
      @(negedge clk);
      drive(0, 1'b0, op_x);
      drive(1, 1'b1, op_y);
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         #1;
         check($sformatf("bp%0d_rsp_valid", k), rsp_valid,  32'd1);
         check($sformatf("bp%0d_rsp_C", k),     rsp_C,      32'h0000_0007);
         check($sformatf("bp%0d_rsp_D", k),     rsp_D,      32'h10);
         check($sformatf("bp%0d_rsp_id", k),    rsp_id,     32'd0);
         check($sformatf("bp%0d_req0_ready", k), req0_ready, 32'd0);
         check($sformatf("bp%0d_req1_ready", k), req1_ready, 32'd0);
         check($sformatf("bp%0d_op_cnt", k),    op_cnt,     32'd8);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      #1;
      check("bp_done_op_cnt",     op_cnt,     32'd9);
      check("bp_done_rsp_valid",  rsp_valid,  32'd0);
      check("bp_done_req1_ready", req1_ready, 32'd1);
      drive(1, 1'b0, op_y);

      // Operand isolation: req1 changes while req0's operation is in EXEC.
      @(negedge clk);
      drive(0, 1'b1, mk_op(OP_ADD, 32'h0000_1000, 32'h0000_2000, 5'd3, 5'd1, 5'd2, 32'h0000_0000));
      #1;
      check("iso_req0_ready", req0_ready, 32'd1);
      @(negedge clk);
      req0_valid = 1'b0;
      drive(1, 1'b1, op_y);
      #1;
      check("iso_alu_A",    alu_A,    32'h0000_1000);
      check("iso_alu_B",    alu_B,    32'h0000_2000);
      check("iso_alu_Op",   alu_Op,   32'(OP_ADD));
      check("iso_alu_rotn", alu_rotn, 32'd3);
      check("iso_alu_XER",  alu_XER,  32'd0);
      @(negedge clk);
      req1_valid = 1'b0;
      #1;
      check("iso_rsp_C",  rsp_C,  32'h0000_3000);
      check("iso_rsp_D",  rsp_D,  32'h10);
      check("iso_rsp_id", rsp_id, 32'd0);
      check("iso_alu_A_resp", alu_A, 32'h0000_1000);
      @(negedge clk);
      #1;
      check("iso_op_cnt", op_cnt, 32'd10);

      // Reset pulsed during EXEC: the operation is dropped.
      @(negedge clk);
      drive(0, 1'b1, op_x);
      #1;
      check("rx_req0_ready", req0_ready, 32'd1);
      @(negedge clk);
      req0_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rx_rsp_valid", rsp_valid, 32'd0);
      check("rx_op_cnt",    op_cnt,    32'd0);
      check("rx_alu_A",     alu_A,     32'd0);
      check("rx_alu_B",     alu_B,     32'd0);
      check("rx_rsp_C",     rsp_C,     32'd0);
      check("rx_rsp_D",     rsp_D,     32'd0);
      check("rx_rsp_id",    rsp_id,    32'd0);
      req0_valid = 1'b1;
      #1;
      check("rx_req0_ready_in_rst", req0_ready, 32'd0);
      req0_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         check($sformatf("rx%0d_rsp_valid", k), rsp_valid, 32'd0);
         check($sformatf("rx%0d_op_cnt", k),    op_cnt,    32'd0);
      end

      // Ties after reset: req0, then req1, then req0.
      @(negedge clk);
      drive(0, 1'b1, op_t0);
      drive(1, 1'b1, op_t1);
      for (int r = 0; r < 3; r++) begin
         #1;
         check($sformatf("tie%0d_req0_ready", r), req0_ready, (r == 1) ? 32'd0 : 32'd1);
         check($sformatf("tie%0d_req1_ready", r), req1_ready, (r == 1) ? 32'd1 : 32'd0);
         @(negedge clk);
         if (r == 2) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
         end
         #1;
         check($sformatf("tie%0d_exec_ready", r), {req0_ready, req1_ready}, 32'd0);
         @(negedge clk);
         #1;
         check($sformatf("tie%0d_rsp_id", r), rsp_id, (r == 1) ? 32'd1 : 32'd0);
         check($sformatf("tie%0d_rsp_C", r),  rsp_C,  (r == 1) ? 32'd4 : 32'd2);
         @(negedge clk);
         #1;
         check($sformatf("tie%0d_op_cnt", r), op_cnt, r + 1);
      end

      // Saturation: start the counter just below its ceiling.
      @(negedge clk);
      force dut.op_cnt = 16'hFFFD;
      @(negedge clk);
      release dut.op_cnt;
      run_vec(vecs[0], "sat0", 32'h0000_FFFE);
      run_vec(vecs[0], "sat1", 32'h0000_FFFF);
      run_vec(vecs[0], "sat2", 32'h0000_FFFF);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
